// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: memory command encodings, memory-stage FSM
// states and the register-index / datapath widths.
package mips_pkg;

    localparam int REG_IDX_W = 5;
    localparam int DATA_W    = 32;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'b00,
        MEM_LOAD  = 2'b01,
        MEM_STORE = 2'b10,
        MEM_RSVD  = 2'b11
    } mem_cmd_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mem_state_e;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register. Each cycle it either captures the memory-stage
// result or loads a bubble (all fields zero).
module mem_wb_reg
    import mips_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 bubble,
    input  logic                 wb_en,
    input  logic                 mem_r_en,
    input  logic [DATA_W-1:0]    alu_res,
    input  logic [DATA_W-1:0]    mem_data,
    input  logic [REG_IDX_W-1:0] dst,
    input  logic [DATA_W-1:0]    pc,
    output logic                 WB_EN_WB,
    output logic                 MEM_R_EN_WB,
    output logic [DATA_W-1:0]    ALU_res_WB,
    output logic [DATA_W-1:0]    Mem_data_WB,
    output logic [REG_IDX_W-1:0] Dst_WB,
    output logic [DATA_W-1:0]    PC_WB
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst || bubble) begin
            WB_EN_WB    <= 1'b0;
            MEM_R_EN_WB <= 1'b0;
            ALU_res_WB  <= '0;
            Mem_data_WB <= '0;
            Dst_WB      <= '0;
            PC_WB       <= '0;
        end else begin
            WB_EN_WB    <= wb_en;
            MEM_R_EN_WB <= mem_r_en;
            ALU_res_WB  <= alu_res;
            Mem_data_WB <= mem_data;
            Dst_WB      <= dst;
            PC_WB       <= pc;
        end
    end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MIPS memory stage: handshaked data-memory word access, pipeline stall and
// MEM/WB capture. Optional access timeout with sticky mem_err: MEM_TIMEOUT_EN.
module mem_stage_ctrl
    import mips_pkg::*;
#(
    parameter int          ADDR_W         = 10,
    parameter logic [31:0] BASE_ADDR      = 32'd1024,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_W-1:0]    PC_in,
    input  logic                 WB_EN_MEM,
    input  logic [1:0]           MEM_CMD_MEM,
    input  logic [DATA_W-1:0]    ALU_res_MEM,
    input  logic [DATA_W-1:0]    src2_val_MEM,
    input  logic [REG_IDX_W-1:0] Dst_MEM,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [DATA_W-1:0]    mem_wdata,
    input  logic [DATA_W-1:0]    mem_rdata,
    input  logic                 mem_ack,
    output logic                 mem_stall,
    output logic                 WB_EN_WB,
    output logic                 MEM_R_EN_WB,
    output logic [DATA_W-1:0]    ALU_res_WB,
    output logic [DATA_W-1:0]    Mem_data_WB,
    output logic [REG_IDX_W-1:0] Dst_WB,
`ifdef MEM_TIMEOUT_EN
    output logic                 mem_err,
`endif
    output logic [DATA_W-1:0]    PC_WB
);

    mem_state_e          state_q, state_d;
    logic [DATA_W-1:0]   byte_off;
    logic                is_load, is_store;
    logic                bubble, wb_mem_r_en, timeout_hit;
    logic [DATA_W-1:0]   wb_mem_data;
    logic                unused_addr_bits;

    // Out-of-range addresses simply wrap: only the word-index bits are kept.
    assign byte_off         = ALU_res_MEM - BASE_ADDR;
    assign mem_addr         = byte_off[ADDR_W+1:2];
    assign unused_addr_bits = ^{byte_off[DATA_W-1:ADDR_W+2], byte_off[1:0]};

    assign is_load   = (MEM_CMD_MEM == MEM_LOAD);
    assign is_store  = (MEM_CMD_MEM == MEM_STORE);
    assign mem_we    = is_store;
    assign mem_wdata = src2_val_MEM;
    assign mem_req   = (state_q == ST_BUSY);

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] to_cnt;

    assign timeout_hit = (state_q == ST_BUSY) && (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt  <= '0;
            mem_err <= 1'b0;
        end else begin
            to_cnt <= (state_q == ST_BUSY) ? to_cnt + 1'b1 : '0;
            if (timeout_hit && !mem_ack)
                mem_err <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        mem_stall   = 1'b0;
        bubble      = 1'b0;
        wb_mem_r_en = 1'b0;
        wb_mem_data = '0;
        case (state_q)
            ST_IDLE: begin
                if (is_load || is_store) begin
                    mem_stall = 1'b1;
                    bubble    = 1'b1;
                    state_d   = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (mem_ack) begin
                    state_d = ST_IDLE;
                    if (is_load) begin
                        wb_mem_r_en = 1'b1;
                        wb_mem_data = mem_rdata;
                    end
                end else if (timeout_hit) begin
                    // Abandoned access retires as a bubble so the pipeline can move on.
                    state_d = ST_IDLE;
                    bubble  = 1'b1;
                end else begin
                    mem_stall = 1'b1;
                    bubble    = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    mem_wb_reg u_mem_wb_reg (
        .clk         (clk),
        .rst         (rst),
        .bubble      (bubble),
        .wb_en       (WB_EN_MEM),
        .mem_r_en    (wb_mem_r_en),
        .alu_res     (ALU_res_MEM),
        .mem_data    (wb_mem_data),
        .dst         (Dst_MEM),
        .pc          (PC_in),
        .WB_EN_WB    (WB_EN_WB),
        .MEM_R_EN_WB (MEM_R_EN_WB),
        .ALU_res_WB  (ALU_res_WB),
        .Mem_data_WB (Mem_data_WB),
        .Dst_WB      (Dst_WB),
        .PC_WB       (PC_WB)
    );

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- Memory stage of the 5-stage MIPS pipeline. Sits directly downstream of the EXE/MEM pipeline register.
- Consumes WB enable, memory command, ALU result, store data, destination register and PC.
- Runs a handshaked word access to an external data memory and stalls the pipeline until the memory acknowledges.
- Registers the results into the MEM/WB boundary for the write-back stage.

Parameters:
- ADDR_W, 10, word-address width driven to data memory
- BASE_ADDR, 32'd1024, byte address mapped to data-memory word 0
- TIMEOUT_CYCLES, 16, BUSY cycles before abort (only with MEM_TIMEOUT_EN)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- PC_in  in  32  PC from EXE/MEM register
- WB_EN_MEM  in  1  write-back enable
- MEM_CMD_MEM  in  2  00 none, 01 load, 10 store, 11 reserved (treated as none)
- ALU_res_MEM  in  32  ALU result / byte address
- src2_val_MEM  in  32  store data
- Dst_MEM  in  5  destination register
- mem_req  out  1  memory request
- mem_we  out  1  1 = write
- mem_addr  out  ADDR_W  word address
- mem_wdata  out  32  write data
- mem_rdata  in  32  read data, valid with mem_ack
- mem_ack  in  1  one-cycle completion pulse
- mem_stall  out  1  freeze PC, IF/ID, ID/EXE, EXE/MEM; insert bubble
- WB_EN_WB  out  1  registered WB enable
- MEM_R_EN_WB  out  1  registered "result is load data"
- ALU_res_WB  out  32  registered ALU result
- Mem_data_WB  out  32  registered load data
- Dst_WB  out  5  registered destination
- PC_WB  out  32  registered PC
- mem_err  out  1  sticky timeout flag (only with MEM_TIMEOUT_EN)

Behaviour:
- Reset (rst=0, async): state=IDLE. All registered outputs 0. mem_req=0 immediately, even mid-access. The access is abandoned and no result is written.
- Address decode: mem_addr = ((ALU_res_MEM - BASE_ADDR) >> 2)[ADDR_W-1:0]. Low two bits are ignored. Out-of-range addresses wrap modulo 2^ADDR_W.
- mem_we = (cmd==store); mem_wdata = src2_val_MEM. Both are combinational from inputs.
- Upstream must hold its inputs stable while mem_stall=1.
- FSM IDLE:
  - cmd none or reserved: mem_stall=0; MEM/WB captures inputs at the edge with MEM_R_EN_WB=0. One-cycle latency.
  - cmd load or store: mem_stall=1; go to BUSY; MEM/WB loads a bubble (all fields 0).
- FSM BUSY:
  - mem_req=1.
  - ack=0: mem_stall=1; bubble into MEM/WB; stay in BUSY.
  - ack=1: mem_stall=0; MEM/WB captures the instruction; go to IDLE.
    - Load: Mem_data_WB=mem_rdata, MEM_R_EN_WB=1.
    - Store: Mem_data_WB=0, MEM_R_EN_WB=0, WB_EN_WB as supplied (normally 0).
- Minimum memory-instruction latency is 2 cycles (1 stall cycle). Back-to-back memory instructions each re-enter BUSY via IDLE.
- mem_ack while in IDLE is ignored.
- Bubble = WB_EN_WB=0, MEM_R_EN_WB=0, all other MEM/WB fields 0.

Optional Feature:
- Macro MEM_TIMEOUT_EN.
- Defined:
  - A counter runs in BUSY and clears on entry.
  - Reaching TIMEOUT_CYCLES without ack aborts the access: state→IDLE, mem_stall=0 that cycle.
  - The instruction is committed as a bubble (WB_EN_WB=0).
  - mem_err sets and stays set until reset.
- Undefined:
  - No counter and no mem_err port.
  - BUSY waits indefinitely for ack.

Decomposition:
- Shared package mips_pkg holds:
  - MEM_CMD encodings (MEM_NONE, MEM_LOAD, MEM_STORE)
  - FSM state enum (ST_IDLE, ST_BUSY)
  - Register-index width (5) and data width (32)
- One sub-module, mem_wb_reg: the MEM/WB pipeline register with async active-low reset and a "bubble" select input. The FSM and address decode stay in mem_stage_ctrl.

Test Plan:
- Reset: hold rst=0 with a load pending → mem_req=0, all WB outputs 0, state IDLE. Release → access starts next edge.
- ALU pass-through: cmd=00, ALU_res=0x00000055, Dst=3, WB_EN=1 → next edge ALU_res_WB=0x55, Dst_WB=3, WB_EN_WB=1, no stall.
- Load, ack after 3 BUSY cycles: ALU_res=1032, mem_rdata=0xDEADBEEF, Dst=7.
  - mem_addr=2; mem_stall high for 4 cycles; bubbles meanwhile.
  - Then Mem_data_WB=0xDEADBEEF, MEM_R_EN_WB=1, Dst_WB=7.
- Store: ALU_res=1028, src2=0x12345678, ack in first BUSY cycle → mem_we=1, mem_addr=1, mem_wdata=0x12345678, 1 stall cycle, WB_EN_WB=0.
- Reset mid-BUSY: assert rst=0 during a load wait → mem_req drops asynchronously. The later stray ack in IDLE has no effect.
- MEM_TIMEOUT_EN: no ack for 16 BUSY cycles → stall releases, bubble committed, mem_err=1 and held until reset.
